// File: rtl/dmem_port_sched.sv
// dmem_port_sched
// Arbitrates the single data-cache port between the load functional unit
// and the head of the committed-store drain queue. It owns the memory
// handshake, back-pressures load issue, broadcasts load results and
// signals store retirement.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-low reset
//   ld_req/addr/funct3/rob/br_mask, ld_busy       load issue side
//   st_req/addr/wmask/wdata, st_ack, st_committed  store drain side
//   flush, flush_mask          branch mispredict kill
//   dmem_addr/rmask/wmask/wdata, dmem_resp/rdata  cache port
//   cdb_valid/rob/data         load result broadcast
//
// Optional build macro DMEM_SCHED_PERF_EN adds the saturating counters
// perf_ld_cnt, perf_st_cnt and perf_ld_stall_cnt.
module dmem_port_sched #(
    parameter int ROB_WIDTH     = 3,
    parameter int BR_TAG_WIDTH  = 4,
    parameter int MAX_ST_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_req,
    input  logic [31:0]             ld_addr,
    input  logic [2:0]              ld_funct3,
    input  logic [ROB_WIDTH-1:0]    ld_rob,
    input  logic [BR_TAG_WIDTH-1:0] ld_br_mask,
    output logic                    ld_busy,
    input  logic                    st_req,
    input  logic [31:0]             st_addr,
    input  logic [3:0]              st_wmask,
    input  logic [31:0]             st_wdata,
    output logic                    st_ack,
    output logic                    st_committed,
    input  logic                    flush,
    input  logic [BR_TAG_WIDTH-1:0] flush_mask,
    output logic [31:0]             dmem_addr,
    output logic [3:0]              dmem_rmask,
    output logic [3:0]              dmem_wmask,
    output logic [31:0]             dmem_wdata,
    input  logic                    dmem_resp,
    input  logic [31:0]             dmem_rdata,
    output logic                    cdb_valid,
    output logic [ROB_WIDTH-1:0]    cdb_rob,
    output logic [31:0]             cdb_data
`ifdef DMEM_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_ld_cnt,
    output logic [31:0]             perf_st_cnt,
    output logic [31:0]             perf_ld_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT, LD_DRAIN} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_ST_STREAK);

    state_t                  state_q;
    logic [3:0]              streak_q;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;
    logic [ROB_WIDTH-1:0]    rob_q;
    logic [BR_TAG_WIDTH-1:0] br_mask_q;
    logic [31:0]             dmem_addr_q;
    logic [3:0]              dmem_rmask_q;
    logic [3:0]              dmem_wmask_q;
    logic [31:0]             dmem_wdata_q;
    logic                    cdb_valid_q;
    logic [ROB_WIDTH-1:0]    cdb_rob_q;
    logic [31:0]             cdb_data_q;
    logic                    st_committed_q;

    logic       in_idle;
    logic       ld_kill_req;
    logic       ld_kill_held;
    logic       ld_pri;
    logic       st_gnt;
    logic       ld_gnt;
    logic [3:0] ld_rmask;
    logic [31:0] ld_shifted;
    logic [31:0] ld_ext;

    // Grants are held off while reset is asserted so st_ack stays low.
    assign in_idle      = (state_q == IDLE) && rst;
    assign ld_kill_req  = flush && |(ld_br_mask & flush_mask);
    assign ld_kill_held = flush && |(br_mask_q & flush_mask);
    // A waiting load takes priority once the store streak reaches its limit;
    // a load being killed this cycle cannot claim the port.
    assign ld_pri  = ld_req && !ld_kill_req && (streak_q >= STREAK_MAX);
    assign st_gnt  = in_idle && st_req && !ld_pri;
    assign ld_gnt  = in_idle && ld_req && !ld_kill_req && !st_gnt;
    assign ld_busy = (state_q != IDLE) || st_gnt;
    assign st_ack  = st_gnt;

    // funct3[1:0] encodes access size for both signed and unsigned loads.
    always_comb begin
        ld_rmask = 4'hF;
        case (ld_funct3[1:0])
            2'b00:   ld_rmask = 4'b0001 << ld_addr[1:0];
            2'b01:   ld_rmask = 4'b0011 << ld_addr[1:0];
            default: ld_rmask = 4'hF;
        endcase
    end

    assign ld_shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shifted;
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_ext = {24'b0, ld_shifted[7:0]};
            3'b101:  ld_ext = {16'b0, ld_shifted[15:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            streak_q       <= 4'd0;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            rob_q          <= '0;
            br_mask_q      <= '0;
            dmem_addr_q    <= 32'd0;
            dmem_rmask_q   <= 4'd0;
            dmem_wmask_q   <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            cdb_valid_q    <= 1'b0;
            cdb_rob_q      <= '0;
            cdb_data_q     <= 32'd0;
            st_committed_q <= 1'b0;
        end else begin
            cdb_valid_q    <= 1'b0;
            st_committed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_gnt || !ld_req) begin
                        streak_q <= 4'd0;
                    end else if (st_gnt && streak_q != 4'hF) begin
                        streak_q <= streak_q + 4'd1;
                    end
                    if (st_gnt) begin
                        state_q      <= ST_WAIT;
                        dmem_addr_q  <= st_addr & 32'hFFFF_FFFC;
                        dmem_wmask_q <= st_wmask;
                        dmem_wdata_q <= st_wdata;
                        dmem_rmask_q <= 4'd0;
                    end else if (ld_gnt) begin
                        state_q      <= LD_WAIT;
                        dmem_addr_q  <= ld_addr & 32'hFFFF_FFFC;
                        dmem_rmask_q <= ld_rmask;
                        dmem_wmask_q <= 4'd0;
                        funct3_q     <= ld_funct3;
                        off_q        <= ld_addr[1:0];
                        rob_q        <= ld_rob;
                        br_mask_q    <= ld_br_mask;
                    end
                end
                LD_WAIT: begin
                    if (dmem_resp) begin
                        state_q      <= IDLE;
                        dmem_rmask_q <= 4'd0;
                        // A kill arriving with the response suppresses the result.
                        if (!ld_kill_held) begin
                            cdb_valid_q <= 1'b1;
                            cdb_rob_q   <= rob_q;
                            cdb_data_q  <= ld_ext;
                        end
                    end else if (ld_kill_held) begin
                        state_q <= LD_DRAIN;
                    end
                end
                LD_DRAIN: begin
                    // The cache access is already in progress; wait it out.
                    if (dmem_resp) begin
                        state_q      <= IDLE;
                        dmem_rmask_q <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp) begin
                        state_q        <= IDLE;
                        dmem_wmask_q   <= 4'd0;
                        st_committed_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_addr    = dmem_addr_q;
    assign dmem_rmask   = dmem_rmask_q;
    assign dmem_wmask   = dmem_wmask_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign cdb_valid    = cdb_valid_q;
    assign cdb_rob      = cdb_rob_q;
    assign cdb_data     = cdb_data_q;
    assign st_committed = st_committed_q;

`ifdef DMEM_SCHED_PERF_EN
    logic [31:0] perf_ld_q;
    logic [31:0] perf_st_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ld_q    <= 32'd0;
            perf_st_q    <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (state_q == LD_WAIT && dmem_resp && !ld_kill_held && perf_ld_q != 32'hFFFF_FFFF) begin
                perf_ld_q <= perf_ld_q + 32'd1;
            end
            if (state_q == ST_WAIT && dmem_resp && perf_st_q != 32'hFFFF_FFFF) begin
                perf_st_q <= perf_st_q + 32'd1;
            end
            if (ld_req && ld_busy && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ld_cnt       = perf_ld_q;
    assign perf_st_cnt       = perf_st_q;
    assign perf_ld_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_port_sched.sv
module tb_dmem_port_sched;

    localparam int ROB_W = 3;
    localparam int BR_W  = 4;
    localparam int MAXS  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_funct3;
    logic [ROB_W-1:0]  ld_rob;
    logic [BR_W-1:0]   ld_br_mask;
    logic              ld_busy;
    logic              st_req;
    logic [31:0]       st_addr;
    logic [3:0]        st_wmask;
    logic [31:0]       st_wdata;
    logic              st_ack;
    logic              st_committed;
    logic              flush;
    logic [BR_W-1:0]   flush_mask;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic              dmem_resp;
    logic [31:0]       dmem_rdata;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob;
    logic [31:0]       cdb_data;
`ifdef DMEM_SCHED_PERF_EN
    logic [31:0]       perf_ld_cnt;
    logic [31:0]       perf_st_cnt;
    logic [31:0]       perf_ld_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dmem_port_sched #(
        .ROB_WIDTH    (ROB_W),
        .BR_TAG_WIDTH (BR_W),
        .MAX_ST_STREAK(MAXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_funct3   (ld_funct3),
        .ld_rob      (ld_rob),
        .ld_br_mask  (ld_br_mask),
        .ld_busy     (ld_busy),
        .st_req      (st_req),
        .st_addr     (st_addr),
        .st_wmask    (st_wmask),
        .st_wdata    (st_wdata),
        .st_ack      (st_ack),
        .st_committed(st_committed),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .dmem_addr   (dmem_addr),
        .dmem_rmask  (dmem_rmask),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_resp   (dmem_resp),
        .dmem_rdata  (dmem_rdata),
        .cdb_valid   (cdb_valid),
        .cdb_rob     (cdb_rob),
        .cdb_data    (cdb_data)
`ifdef DMEM_SCHED_PERF_EN
        ,
        .perf_ld_cnt      (perf_ld_cnt),
        .perf_st_cnt      (perf_st_cnt),
        .perf_ld_stall_cnt(perf_ld_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte lanes touched by a load of the given size at offset off.
    function automatic logic [3:0] exp_rmask(input logic [2:0] f3, input int off);
        int nbytes;
        int lanes;
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lanes  = ((1 << nbytes) - 1) << off;
        return 4'(lanes);
    endfunction

    // Reference: extract nbytes starting at byte off, then extend arithmetically.
    function automatic logic [31:0] exp_data(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        int    nbytes;
        longint full;
        longint v;
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        full   = longint'(1) << (8 * nbytes);
        v      = (longint'(rdata) / (longint'(1) << (8 * off))) % full;
        if (!f3[2] && nbytes < 4 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        ld_req = 0; ld_addr = 0; ld_funct3 = 0; ld_rob = 0; ld_br_mask = 0;
        st_req = 0; st_addr = 0; st_wmask = 0; st_wdata = 0;
        flush = 0; flush_mask = 0; dmem_resp = 0; dmem_rdata = 0;
    endtask

    // Issue one load, respond after lat cycles, optionally flush at cycle flush_at.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [ROB_W-1:0] rob,
                           input logic [BR_W-1:0] bm, input logic [31:0] rdata, input int lat,
                           input int flush_at, input logic [BR_W-1:0] fm);
        logic [3:0]  em;
        logic [31:0] ed;
        bit          killed;
        em = exp_rmask(f3, int'(addr[1:0]));
        ed = exp_data(f3, int'(addr[1:0]), rdata);
        killed = (flush_at >= 0) && (flush_at < lat) && ((bm & fm) != 0);
        ld_req = 1; ld_addr = addr; ld_funct3 = f3; ld_rob = rob; ld_br_mask = bm;
        #1;
        chk("ld_busy_at_issue", 32'(ld_busy), 0);
        @(negedge clk);
        ld_req = 0;
        #1;
        chk("ld_rmask", 32'(dmem_rmask), 32'(em));
        chk("ld_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("ld_wmask", 32'(dmem_wmask), 0);
        for (int i = 0; i < lat; i++) begin
            dmem_resp  = (i == lat - 1);
            dmem_rdata = dmem_resp ? rdata : $urandom;
            flush      = (i == flush_at);
            flush_mask = fm;
            #1;
            chk("ld_busy_wait", 32'(ld_busy), 1);
            chk("ld_rmask_wait", 32'(dmem_rmask), 32'(em));
            chk("ld_cdb_early", 32'(cdb_valid), 0);
            @(negedge clk);
            dmem_resp = 0; flush = 0;
        end
        #1;
        chk("ld_cdb_valid", 32'(cdb_valid), killed ? 0 : 1);
        if (!killed) begin
            chk("ld_cdb_data", cdb_data, ed);
            chk("ld_cdb_rob", 32'(cdb_rob), 32'(rob));
        end
        chk("ld_rmask_done", 32'(dmem_rmask), 0);
        chk("ld_busy_done", 32'(ld_busy), 0);
        @(negedge clk);
        #1;
        chk("ld_cdb_pulse", 32'(cdb_valid), 0);
        $display("load  addr=%08h f3=%0d rob=%0d lat=%0d killed=%0d data=%08h", addr, f3, rob, lat, killed, ed);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd,
                            input int lat, input bit flush_during);
        st_req = 1; st_addr = addr; st_wmask = wm; st_wdata = wd;
        #1;
        chk("st_ack_grant", 32'(st_ack), 1);
        chk("st_ld_busy_grant", 32'(ld_busy), 1);
        @(negedge clk);
        st_req = 0;
        #1;
        chk("st_ack_pulse", 32'(st_ack), 0);
        chk("st_wmask", 32'(dmem_wmask), 32'(wm));
        chk("st_wdata", dmem_wdata, wd);
        chk("st_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("st_rmask", 32'(dmem_rmask), 0);
        for (int i = 0; i < lat; i++) begin
            dmem_resp  = (i == lat - 1);
            flush      = flush_during && (i == 0);
            flush_mask = 4'hF;
            #1;
            chk("st_committed_early", 32'(st_committed), 0);
            @(negedge clk);
            dmem_resp = 0; flush = 0;
        end
        #1;
        chk("st_committed", 32'(st_committed), 1);
        chk("st_cdb_quiet", 32'(cdb_valid), 0);
        chk("st_wmask_done", 32'(dmem_wmask), 0);
        @(negedge clk);
        #1;
        chk("st_committed_pulse", 32'(st_committed), 0);
        $display("store addr=%08h wmask=%h data=%08h lat=%0d flush=%0d", addr, wm, wd, lat, flush_during);
    endtask

    task automatic arb_test();
        int stores_seen;
        int grants;
        int acks_before_load;
        bit seen_load;
        bit obs_load;
        bit exp_load;
        stores_seen = 0; grants = 0; acks_before_load = 0; seen_load = 0;
        ld_req = 1; ld_addr = 32'h100; ld_funct3 = 3'b010; ld_rob = 3'd5; ld_br_mask = 0;
        st_req = 1; st_addr = 32'h200; st_wmask = 4'hF; st_wdata = 32'h1234_5678;
        for (int cyc = 0; cyc < 60 && grants < 12; cyc++) begin
            dmem_resp = 0;
            #1;
            if (st_ack || !ld_busy) begin
                obs_load = !st_ack;
                exp_load = (stores_seen == MAXS);
                chk("arb_grant", 32'(obs_load), 32'(exp_load));
                if (obs_load) begin
                    stores_seen = 0;
                    seen_load = 1;
                end else begin
                    stores_seen++;
                    if (!seen_load) acks_before_load++;
                end
                grants++;
            end else begin
                dmem_resp = 1;
            end
            @(negedge clk);
        end
        chk("arb_grant_count", 32'(grants), 12);
        chk("arb_acks_before_load", 32'(acks_before_load), MAXS);
        ld_req = 0; st_req = 0; dmem_resp = 1;
        @(negedge clk);
        dmem_resp = 0;
        @(negedge clk);
        #1;
        chk("arb_idle_after", 32'(ld_busy), 0);
        $display("arbitration grants=%0d stores_before_first_load=%0d", grants, acks_before_load);
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ld_busy", 32'(ld_busy), 0);
        chk("rst_rmask", 32'(dmem_rmask), 0);
        chk("rst_wmask", 32'(dmem_wmask), 0);
        chk("rst_cdb_valid", 32'(cdb_valid), 0);
        chk("rst_st_ack", 32'(st_ack), 0);
        chk("rst_st_committed", 32'(st_committed), 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Directed cases.
        do_load(32'h0000_1003, 3'b100, 3'd6, 4'b0000, 32'h80FF_0000, 2, -1, 4'b0000);
        do_load(32'h0000_2002, 3'b001, 3'd2, 4'b0000, 32'h8001_1234, 1, -1, 4'b0000);
        arb_test();
        do_store(32'h0000_3000, 4'h3, 32'hDEAD_BEEF, 2, 1'b0);
        do_store(32'h0000_3004, 4'hC, 32'hCAFE_F00D, 3, 1'b1);
        do_load(32'h0000_4000, 3'b010, 3'd1, 4'b0010, 32'h1111_2222, 4, 0, 4'b0010);
        do_load(32'h0000_4004, 3'b010, 3'd3, 4'b0010, 32'h3333_4444, 4, 0, 4'b0100);
        do_load(32'h0000_4008, 3'b000, 3'd4, 4'b1000, 32'h0000_00AA, 2, 1, 4'b1000);

        // A matching flush in the grant cycle blocks the load.
        ld_req = 1; ld_addr = 32'h500; ld_funct3 = 3'b010; ld_br_mask = 4'b0010;
        flush = 1; flush_mask = 4'b0010;
        #1;
        chk("flush_block_busy", 32'(ld_busy), 0);
        @(negedge clk);
        ld_req = 0; flush = 0;
        #1;
        chk("flush_block_rmask", 32'(dmem_rmask), 0);
        chk("flush_block_idle", 32'(ld_busy), 0);
        $display("flush-blocked load grant");
        @(negedge clk);

        // Reset in the middle of a load, then a stray response.
        ld_req = 1; ld_addr = 32'h600; ld_funct3 = 3'b010; ld_rob = 3'd7; ld_br_mask = 0;
        @(negedge clk);
        ld_req = 0;
        #1;
        chk("mid_busy", 32'(ld_busy), 1);
        rst = 0;
        #1;
        chk("mid_rst_busy", 32'(ld_busy), 0);
        chk("mid_rst_rmask", 32'(dmem_rmask), 0);
        chk("mid_rst_cdb", 32'(cdb_valid), 0);
        chk("mid_rst_st_ack", 32'(st_ack), 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_resp = 0;
        #1;
        chk("stray_cdb", 32'(cdb_valid), 0);
        chk("stray_st_committed", 32'(st_committed), 0);
        chk("stray_busy", 32'(ld_busy), 0);
        $display("reset mid-load, stray response ignored");
        @(negedge clk);
        do_load(32'h0000_0701, 3'b000, 3'd0, 4'b0000, 32'h0000_8000, 1, -1, 4'b0000);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [2:0]  f3;
                logic [31:0] a;
                int          off;
                int          fa;
                f3 = f3_tab[$urandom_range(0, 4)];
                if (f3[1:0] == 2'b00) off = $urandom_range(0, 3);
                else if (f3[1:0] == 2'b01) off = 2 * $urandom_range(0, 1);
                else off = 0;
                a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
                fa = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 3);
                do_load(a, f3, 3'($urandom), 4'($urandom), $urandom, $urandom_range(1, 4),
                        fa, 4'($urandom));
            end else begin
                logic [3:0] wm;
                wm = 4'($urandom_range(1, 15));
                do_store($urandom, wm, $urandom, $urandom_range(1, 4), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_sched.md
Name: dmem_port_sched

Overview:
- Schedules the single data-cache port between the load functional unit (fed by the load reservation station issue) and the committed-store drain queue head.
- Owns the memory handshake. Back-pressures the load RS via ld_busy.
- Broadcasts load results toward the CDB and pulses st_committed to the load RS after each store retires to memory.
- Discards in-flight loads killed by a branch flush.

Parameters:
- ROB_WIDTH, 3, width of ROB tag carried by a load.
- BR_TAG_WIDTH, 4, width of branch-dependency mask.
- MAX_ST_STREAK, 4, consecutive store grants allowed while a load waits (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- ld_req  in  1  load request valid (load RS issue).
- ld_addr  in  32  byte address.
- ld_funct3  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_rob  in  ROB_WIDTH  destination ROB tag.
- ld_br_mask  in  BR_TAG_WIDTH  branches the load depends on.
- ld_busy  out  1  load path occupied; load RS must not issue.
- st_req  in  1  committed store at drain-queue head.
- st_addr  in  32  word-aligned address.
- st_wmask  in  4  byte write mask.
- st_wdata  in  32  write data.
- st_ack  out  1  one-cycle pulse: head store accepted; queue pops.
- st_committed  out  1  one-cycle pulse when store memory response returns.
- flush  in  1  branch mispredict flush.
- flush_mask  in  BR_TAG_WIDTH  mispredicted-branch bit(s).
- dmem_addr  out  32  word-aligned address (addr[1:0] forced 0).
- dmem_rmask  out  4  read byte mask.
- dmem_wmask  out  4  write byte mask.
- dmem_wdata  out  32  write data.
- dmem_resp  in  1  cache response (1 cycle).
- dmem_rdata  in  32  read data.
- cdb_valid  out  1  load result valid.
- cdb_rob  out  ROB_WIDTH  result ROB tag.
- cdb_data  out  32  extended load data.

Behaviour:
- FSM states and transitions:
  - IDLE -> LD_WAIT when a load is granted.
  - IDLE -> ST_WAIT when a store is granted.
  - LD_WAIT -> IDLE on dmem_resp.
  - ST_WAIT -> IDLE on dmem_resp.
  - LD_WAIT -> LD_DRAIN when flush and (held br_mask & flush_mask) != 0.
  - LD_DRAIN -> IDLE on dmem_resp, result discarded.
- Grant occurs in IDLE only.
  - Both requests present: store wins unless streak == MAX_ST_STREAK, then load wins.
  - streak: 4-bit counter, increments on a store grant while ld_req is high; clears on a load grant or when ld_req is low in IDLE.
- On grant, request fields are registered. dmem_rmask/wmask are driven nonzero from the cycle after the grant until dmem_resp, inclusive; otherwise 0.
- Load rmask from funct3 and addr[1:0]:
  - byte: 1<<off.
  - half: 3<<off.
  - word: 0xF.
  - Alignment is guaranteed upstream; it is not checked.
- ld_busy = 1 in IDLE when a store is being granted this cycle, and in LD_WAIT, LD_DRAIN and ST_WAIT. ld_busy = 0 otherwise.
- A load is accepted only when ld_req && !ld_busy. A store is accepted only in IDLE; st_ack pulses in the grant cycle.
- Load result:
  - cdb_valid is registered and asserts the cycle after dmem_resp in LD_WAIT, for 1 cycle.
  - Data is shifted by off*8, then sign- or zero-extended per funct3.
  - If flush kills the load in the same cycle as dmem_resp, cdb_valid stays 0.
- Flush handling:
  - Flush never affects a store in ST_WAIT (stores are committed).
  - Flush with a matching ld_br_mask in the IDLE grant cycle blocks that grant.
- st_committed is registered and pulses the cycle after dmem_resp in ST_WAIT.
- Reset: state IDLE, streak 0, all outputs 0 (ld_busy 0, masks 0, cdb_valid 0, st_ack 0, st_committed 0). Reset mid-transaction abandons it; any later dmem_resp arriving in IDLE is ignored.

Optional Feature:
- DMEM_SCHED_PERF_EN defined:
  - Adds 32-bit outputs perf_ld_cnt and perf_st_cnt (completed loads/stores) and perf_ld_stall_cnt (cycles with ld_req && ld_busy).
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load LBU addr 0x1003, rdata 0x80FF_0000, resp after 2 cycles: rmask=4'b1000, cdb_data=0x0000_0080, cdb_rob=ld_rob, 1-cycle cdb_valid.
- Load LH addr 0x2002, rdata 0x8001_1234: rmask=4'b1100, cdb_data=0xFFFF_8001.
- Store and load requested together continuously, MAX_ST_STREAK=4: grant order S,S,S,S,L; streak resets; st_ack count before the load is 4.
- Store wmask 0x3, data 0xDEAD_BEEF, resp: st_committed pulses exactly once, the cycle after resp; cdb_valid stays 0.
- Load br_mask 0b0010 in flight, flush with flush_mask 0b0010, resp 3 cycles later: state LD_DRAIN, no cdb_valid, ld_busy held until resp; flush_mask 0b0100 instead leaves the load unaffected.
- rst driven low during LD_WAIT, released, then stray dmem_resp: all outputs 0, no cdb_valid, next grant proceeds normally.
